fifo_junior: RTL and testbench
==============================

# fifo_junior

Single-clock, synchronous first-in-first-out buffer for 8-bit data words, depth 16. It decouples a byte producer from a byte consumer in the same clock domain. It drops writes when full and ignores reads when empty, and exposes full/empty status flags to both sides.

## Interface
- DATA_W, 8, data word width
- DEPTH, 16, number of storage entries (power of two)
- clk_i  input  1  single clock, all state on rising edge
- rst_i  input  1  reset, asynchronous and active-low
- write  input  1  write request; pushes data_in at the rising edge when accepted
- read  input  1  read request; pops the oldest entry at the rising edge when accepted
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  registered read data
- fifo_empty  output  1  high when the stored count is 0
- fifo_full  output  1  high when the stored count equals DEPTH

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_W = log2(DEPTH) = 4 bits
  - occupancy `count`, ADDR_W+1 = 5 bits, range 0..16
  - storage array of DEPTH × DATA_W
- Write accepted = write & (!fifo_full | read_accepted):
  - mem[wr_ptr] <= data_in
  - wr_ptr increments and wraps 15 -> 0
- Read accepted = read & !fifo_empty:
  - data_out <= mem[rd_ptr]
  - rd_ptr increments and wraps 15 -> 0
- count: +1 on a write alone, -1 on a read alone, unchanged when both are accepted.
- Full with read and write together: both are accepted. The oldest entry goes to data_out, the new word fills the freed slot, and count stays at 16.
- Empty with read and write together: only the write is accepted, with no bypass. data_out is unchanged and count becomes 1.
- Write while full and no read: the write is dropped and data is unchanged.
- Read while empty: ignored. data_out holds its value.
- data_out holds its last value whenever no read is accepted.
- fifo_empty = (count == 0) and fifo_full = (count == DEPTH). Both are decoded from the count register only and never depend combinationally on the inputs.
- Storage contents are not reset. A value read after reset always comes from a valid write.

## Timing
- Reset, asserted asynchronously when rst_i = 0:
  - wr_ptr = rd_ptr = 0 and count = 0
  - data_out = 8'h00, fifo_empty = 1, fifo_full = 0
- Reset deassertion takes effect at the next rising edge.
- Write-to-read latency: a word written at edge N can be read from edge N+1. It is visible on data_out immediately after the read edge.
- Read latency: 1 cycle. data_out updates at the edge that accepts the read.
- Flags update at the same edge as count, one cycle after the request is sampled.
- Requests are level-sampled. A request held high for k edges performs k operations, each subject to the full/empty gating.
- Reset mid-operation discards all contents immediately and returns every output to its reset value.

## Structure
- Package fifo_junior_pkg holds:
  - localparams DATA_W = 8, DEPTH = 16, ADDR_W = $clog2(DEPTH), CNT_W = ADDR_W+1
  - typedefs data_t (logic [DATA_W-1:0]), ptr_t, cnt_t
- Sub-module fifo_junior_mem: DEPTH × DATA_W register array with a synchronous write port and an indexed read port. The top level holds the pointers, count, flags and output register.
- Control logic stays in fifo_junior, with no separate FSM. The state is fully described by the pointers and count.

## Test plan
- Reset: drive rst_i = 0 mid-run -> fifo_empty = 1, fifo_full = 0 and data_out = 0 at once, without waiting for a clock edge.
- Fill: write 3, 4, …, 18 (16 words) -> fifo_full = 1 after the 16th edge. Further writes 19..52 are dropped, so count stays 16.
- Drain: read 20 times after the fill -> data_out = 3, 4, …, 18 in order. fifo_empty = 1 after the 16th read, and reads 17..20 leave data_out = 18.
- Wrap: write 10 words, read 10, then write 16 more and read 16 -> order preserved across the 15 -> 0 pointer wrap.
- Simultaneous on empty: read = write = 1 with data_in = 0x55 -> count = 1, data_out unchanged. A following read returns 0x55.
- Simultaneous on full: full with head value 3, then read = write = 1 with data_in = 0xAA -> data_out = 3, fifo_full stays 1, and 0xAA is the last word drained.

Source files
------------

// File: rtl/fifo_junior_pkg.sv
// rtl/fifo_junior_pkg.sv - shared sizes and types for the fifo_junior byte FIFO
// Purpose: word width, depth, pointer/count widths and their typedefs.
// Ports:   none (package).
package fifo_junior_pkg;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/fifo_junior_if.sv
// rtl/fifo_junior_if.sv - producer/consumer handshake bundle for fifo_junior
// Purpose: groups the request, data and status signals of the FIFO.
// Ports (signals):
//   write      producer write request
//   read       consumer read request
//   data_in    write data
//   data_out   registered read data
//   fifo_empty stored count is 0
//   fifo_full  stored count equals DEPTH
// Modports: master = user side (drives requests), slave = FIFO side.
interface fifo_junior_if;
   import fifo_junior_pkg::*;

   logic  write;
   logic  read;
   data_t data_in;
   data_t data_out;
   logic  fifo_empty;
   logic  fifo_full;

   modport master (
      output write, read, data_in,
      input  data_out, fifo_empty, fifo_full
   );

   modport slave (
      input  write, read, data_in,
      output data_out, fifo_empty, fifo_full
   );

endinterface

// File: rtl/fifo_junior_mem.sv
// rtl/fifo_junior_mem.sv - DEPTH x DATA_W storage array for fifo_junior
// Purpose: register array, synchronous write port, combinational indexed read.
// Ports:
//   clk_i  clock
//   we     write enable
//   waddr  write index
//   wdata  write data
//   raddr  read index
//   rdata  contents at raddr (pre-edge value, so a same-edge write to the
//          slot being read returns the old word)
module fifo_junior_mem
   import fifo_junior_pkg::*;
(
   input  logic  clk_i,
   input  logic  we,
   input  ptr_t  waddr,
   input  data_t wdata,
   input  ptr_t  raddr,
   output data_t rdata
);

   // Contents are deliberately not reset; the pointers guarantee that only
   // previously written slots are ever read.
   data_t mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_junior.sv
// rtl/fifo_junior.sv - single-clock 16 x 8 FIFO with drop-on-full, ignore-on-empty
// Purpose: pointers, occupancy count, status flags and registered read data.
// Ports:
//   clk_i  clock, all state on rising edge
//   rst_i  asynchronous active-low reset
//   bus    fifo_junior_if.slave (write/read/data_in in, data_out/flags out)
module fifo_junior
   import fifo_junior_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   fifo_junior_if.slave bus
);

   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

   ptr_t  wr_ptr;
   ptr_t  rd_ptr;
   cnt_t  count;
   data_t dout_q;
   data_t mem_rdata;
   logic  rd_acc;
   logic  wr_acc;

   // Flags come from the count register only, never from the requests.
   assign bus.fifo_empty = (count == '0);
   assign bus.fifo_full  = (count == CNT_FULL);
   assign bus.data_out   = dout_q;

   // A read frees a slot at the same edge, so a full FIFO still takes a
   // write that is paired with an accepted read. An empty FIFO never
   // bypasses the write to the read side.
   assign rd_acc = bus.read  & ~bus.fifo_empty;
   assign wr_acc = bus.write & (~bus.fifo_full | rd_acc);

   fifo_junior_mem u_mem (
      .clk_i (clk_i),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (bus.data_in),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout_q <= '0;
      end else begin
         // Pointers are exactly ADDR_W bits, so increment wraps 15 -> 0.
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ptr_t'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
            dout_q <= mem_rdata;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_junior.sv
// tb/tb_fifo_junior.sv - self-checking bench for fifo_junior
module tb_fifo_junior;
   import fifo_junior_pkg::*;

   logic clk;
   logic rst_n;

   fifo_junior_if bus();

   fifo_junior dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] din;
      logic [7:0] exp_dout;
      logic       exp_empty;
      logic       exp_full;
   } vec_t;

   vec_t       vecs [$];
   logic [7:0] sb_q [$];
   logic [7:0] exp_dout;
   int         n_vec;
   int         n_err;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_state(input string nm);
      chk({nm, ".data_out"}, bus.data_out, exp_dout);
      chk({nm, ".empty"}, {7'd0, bus.fifo_empty}, {7'd0, sb_q.size() == 0});
      chk({nm, ".full"},  {7'd0, bus.fifo_full},  {7'd0, sb_q.size() == DEPTH});
   endtask

   // One clock of stimulus; the scoreboard decides acceptance from its own
   // occupancy before the edge, then the DUT is sampled 1 ns after the edge.
   task automatic step(input logic wr, input logic rd, input logic [7:0] din, input string nm);
      bit ra;
      bit wa;
      @(negedge clk);
      bus.write   = wr;
      bus.read    = rd;
      bus.data_in = din;
      ra = rd && (sb_q.size() > 0);
      wa = wr && ((sb_q.size() < DEPTH) || ra);
      @(posedge clk);
      if (ra) exp_dout = sb_q.pop_front();
      if (wa) sb_q.push_back(din);
      #1;
      chk_state(nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_dout = 8'h00;
      bus.write = 1'b0;
      bus.read = 1'b0;
      bus.data_in = 8'h00;
      rst_n = 1'b0;

      //            wr    rd    din    dout   empty full
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h33, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 8'h55, 8'h33, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0});

      // Reset state before any clock edge
      #1;
      chk("reset.data_out", bus.data_out, 8'h00);
      chk("reset.empty", {7'd0, bus.fifo_empty}, 8'd1);
      chk("reset.full",  {7'd0, bus.fifo_full},  8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors: simple traffic plus simultaneous read/write on empty
      foreach (vecs[i]) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tbl_dout", i), bus.data_out, vecs[i].exp_dout);
         chk($sformatf("vec%0d.tbl_empty", i), {7'd0, bus.fifo_empty}, {7'd0, vecs[i].exp_empty});
         chk($sformatf("vec%0d.tbl_full", i),  {7'd0, bus.fifo_full},  {7'd0, vecs[i].exp_full});
      end

      // Fill 3..18, then writes 19..52 are dropped
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(3 + i), "fill");
      chk("fill.full", {7'd0, bus.fifo_full}, 8'd1);
      for (int i = 19; i <= 52; i++) step(1'b1, 1'b0, 8'(i), "overfill");

      // Drain 20 reads: 3..18 then hold 18
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, "drain");
      chk("drain.last", bus.data_out, 8'd18);
      chk("drain.empty", {7'd0, bus.fifo_empty}, 8'd1);

      // Wrap: 10 in/out, then 16 in/out crosses the pointer wrap
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h60 + i), "wrap.w10");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap.r10");
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, $urandom_range(0, 255), "wrap.w16");
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "wrap.r16");

      // Simultaneous on full: head 3, new 0xAA drained last
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(3 + i), "full2.fill");
      step(1'b1, 1'b1, 8'hAA, "full2.rw");
      chk("full2.rw_dout", bus.data_out, 8'd3);
      chk("full2.rw_full", {7'd0, bus.fifo_full}, 8'd1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "full2.drain");
      chk("full2.last", bus.data_out, 8'hAA);

      // Reset mid-operation: outputs return to reset values without an edge
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), "mid.fill");
      step(1'b0, 1'b1, 8'h00, "mid.read");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset.data_out", bus.data_out, 8'h00);
      chk("midreset.empty", {7'd0, bus.fifo_empty}, 8'd1);
      chk("midreset.full",  {7'd0, bus.fifo_full},  8'd0);
      sb_q.delete();
      exp_dout = 8'h00;
      @(negedge clk);
      bus.write = 1'b0;
      bus.read = 1'b0;
      rst_n = 1'b1;
      step(1'b0, 1'b1, 8'h00, "postreset.read");
      step(1'b1, 1'b0, 8'h77, "postreset.write");
      step(1'b0, 1'b1, 8'h00, "postreset.read2");
      chk("postreset.dout", bus.data_out, 8'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
